vending_machine_ctrl: RTL and testbench

- Coin-operated vending-machine controller.
- An upstream stimulus/keypad block issues select, insert-money and cancel/change commands, with a product code, a money value and per-denomination coin counts.
- The block prices the product, accumulates credit and shows it as BCD digits. It dispenses the product, computes change, and keeps sales revenue and a coin inventory.

---
 rtl/vending_machine_ctrl_if.sv | 39 +++
 rtl/vending_machine_ctrl.sv | 161 ++++++++++++++++
 tb/tb_vending_machine_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/vending_machine_ctrl_if.sv
// Command/payload and status bundle between the keypad/coin front-end and the
// vending-machine controller.
interface vending_machine_ctrl_if;
  logic [1:0] escolher;
  logic [1:0] inserir_dinheiro;
  logic [1:0] dar_troco;
  logic [7:0] produto_escolhido;
  logic [7:0] dinheiro_inserido;
  logic [7:0] moedas_inseridas_25;
  logic [7:0] moedas_inseridas_50;
  logic [7:0] moedas_inseridas_100;
  logic [7:0] produto_vendido;
  logic [7:0] carteira;
  logic [7:0] valor_troco;
  logic [3:0] dinheiro_inserido_c;
  logic [3:0] dinheiro_inserido_d;
  logic [3:0] dinheiro_inserido_u;
  logic [7:0] moedas_carteira_25;
  logic [7:0] moedas_carteira_50;
  logic [7:0] moedas_carteira_100;

  modport master (
    output escolher, inserir_dinheiro, dar_troco, produto_escolhido,
           dinheiro_inserido, moedas_inseridas_25, moedas_inseridas_50,
           moedas_inseridas_100,
    input  produto_vendido, carteira, valor_troco, dinheiro_inserido_c,
           dinheiro_inserido_d, dinheiro_inserido_u, moedas_carteira_25,
           moedas_carteira_50, moedas_carteira_100
  );

  modport slave (
    input  escolher, inserir_dinheiro, dar_troco, produto_escolhido,
           dinheiro_inserido, moedas_inseridas_25, moedas_inseridas_50,
           moedas_inseridas_100,
    output produto_vendido, carteira, valor_troco, dinheiro_inserido_c,
           dinheiro_inserido_d, dinheiro_inserido_u, moedas_carteira_25,
           moedas_carteira_50, moedas_carteira_100
  );
endinterface

// File: rtl/vending_machine_ctrl.sv
// Vending-machine controller: prices a selection, accumulates credit, dispenses,
// returns change and keeps revenue plus a per-denomination coin inventory.
module vending_machine_ctrl #(
  parameter int unsigned PRICE_1 = 75,
  parameter int unsigned PRICE_2 = 100,
  parameter int unsigned PRICE_3 = 125,
  parameter int unsigned PRICE_4 = 150
) (
  input  logic                         clock,
  input  logic                         reset_n,
  vending_machine_ctrl_if.slave        bus
);

  localparam int unsigned W = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PAGAR  = 2'd1;
  localparam logic [1:0] ST_VENDER = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [W-1:0] credit_q, credit_d;
  logic [W-1:0] price_q, price_d;
  logic [W-1:0] code_q, code_d;
  logic [W-1:0] tally25_q, tally25_d;
  logic [W-1:0] tally50_q, tally50_d;
  logic [W-1:0] tally100_q, tally100_d;
  logic [W-1:0] vendido_q, vendido_d;
  logic [W-1:0] carteira_q, carteira_d;
  logic [W-1:0] troco_q, troco_d;
  logic [W-1:0] inv25_q, inv25_d;
  logic [W-1:0] inv50_q, inv50_d;
  logic [W-1:0] inv100_q, inv100_d;

  logic [W-1:0] price_sel;
  logic         code_valid;

  function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = (W+1)'(a) + (W+1)'(b);
    return s[W] ? {W{1'b1}} : s[W-1:0];
  endfunction

  // Product code to price lookup; codes outside 1..4 are not sellable
  always_comb begin
    price_sel  = '0;
    code_valid = 1'b1;
    case (bus.produto_escolhido)
      8'd1:    price_sel = W'(PRICE_1);
      8'd2:    price_sel = W'(PRICE_2);
      8'd3:    price_sel = W'(PRICE_3);
      8'd4:    price_sel = W'(PRICE_4);
      default: code_valid = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    price_d    = price_q;
    code_d     = code_q;
    tally25_d  = tally25_q;
    tally50_d  = tally50_q;
    tally100_d = tally100_q;
    vendido_d  = vendido_q;
    carteira_d = carteira_q;
    troco_d    = troco_q;
    inv25_d    = inv25_q;
    inv50_d    = inv50_q;
    inv100_d   = inv100_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.escolher == 2'b01 && code_valid) begin
          code_d    = bus.produto_escolhido;
          price_d   = price_sel;
          troco_d   = '0;
          vendido_d = '0;
          state_d   = ST_PAGAR;
        end
      end
      ST_PAGAR: begin
        if (bus.dar_troco == 2'b01) begin
          troco_d    = credit_q;
          credit_d   = '0;
          tally25_d  = '0;
          tally50_d  = '0;
          tally100_d = '0;
          state_d    = ST_IDLE;
        end else begin
          if (bus.inserir_dinheiro == 2'b01) begin
            credit_d   = sat_add(credit_q, bus.dinheiro_inserido);
            tally25_d  = sat_add(tally25_q, bus.moedas_inseridas_25);
            tally50_d  = sat_add(tally50_q, bus.moedas_inseridas_50);
            tally100_d = sat_add(tally100_q, bus.moedas_inseridas_100);
          end
          // Decision uses the registered credit; a coincident insert still lands
          if (credit_q >= price_q) state_d = ST_VENDER;
        end
      end
      ST_VENDER: begin
        vendido_d  = code_q;
        troco_d    = credit_q - price_q;
        carteira_d = sat_add(carteira_q, price_q);
        inv25_d    = sat_add(inv25_q, tally25_q);
        inv50_d    = sat_add(inv50_q, tally50_q);
        inv100_d   = sat_add(inv100_q, tally100_q);
        credit_d   = '0;
        tally25_d  = '0;
        tally50_d  = '0;
        tally100_d = '0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      credit_q   <= '0;
      price_q    <= '0;
      code_q     <= '0;
      tally25_q  <= '0;
      tally50_q  <= '0;
      tally100_q <= '0;
      vendido_q  <= '0;
      carteira_q <= '0;
      troco_q    <= '0;
      inv25_q    <= '0;
      inv50_q    <= '0;
      inv100_q   <= '0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      price_q    <= price_d;
      code_q     <= code_d;
      tally25_q  <= tally25_d;
      tally50_q  <= tally50_d;
      tally100_q <= tally100_d;
      vendido_q  <= vendido_d;
      carteira_q <= carteira_d;
      troco_q    <= troco_d;
      inv25_q    <= inv25_d;
      inv50_q    <= inv50_d;
      inv100_q   <= inv100_d;
    end
  end

  assign bus.produto_vendido     = vendido_q;
  assign bus.carteira            = carteira_q;
  assign bus.valor_troco         = troco_q;
  assign bus.moedas_carteira_25  = inv25_q;
  assign bus.moedas_carteira_50  = inv50_q;
  assign bus.moedas_carteira_100 = inv100_q;

  // Credit display digits, decoded straight from the credit register
  assign bus.dinheiro_inserido_c = 4'(credit_q / 8'd100);
  assign bus.dinheiro_inserido_d = 4'((credit_q / 8'd10) % 8'd10);
  assign bus.dinheiro_inserido_u = 4'(credit_q % 8'd10);

endmodule

// File: tb/tb_vending_machine_ctrl.sv
// Scoreboard bench for vending_machine_ctrl: stimulus queues expected output
// snapshots tagged with the cycle they apply to; a negedge monitor checks them.
module tb_vending_machine_ctrl;

  typedef struct {
    int         cyc;
    string      name;
    logic [7:0] pv;
    logic [7:0] cart;
    logic [7:0] troco;
    logic [3:0] c;
    logic [3:0] d;
    logic [3:0] u;
    logic [7:0] m25;
    logic [7:0] m50;
    logic [7:0] m100;
  } exp_t;

  logic clk;
  logic reset_n;
  int   cyc;
  int   n_cmp;
  int   n_bad;
  exp_t sb[$];

  vending_machine_ctrl_if vif ();

  vending_machine_ctrl dut (
    .clock   (clk),
    .reset_n (reset_n),
    .bus     (vif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input string fld, input logic [7:0] act, input logic [7:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s.%s: got %0d expected %0d (t=%0t)", nm, fld, act, exp, $time);
    end
  endtask

  // Monitor: pop and compare every expectation due in the current cycle
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        n_cmp = n_cmp + 1;
        n_bad = n_bad + 1;
        $display("FAIL %s: expectation for cycle %0d missed, now %0d", e.name, e.cyc, cyc);
      end else begin
        chk(e.name, "produto_vendido", vif.produto_vendido, e.pv);
        chk(e.name, "carteira", vif.carteira, e.cart);
        chk(e.name, "valor_troco", vif.valor_troco, e.troco);
        chk(e.name, "bcd_c", 8'(vif.dinheiro_inserido_c), 8'(e.c));
        chk(e.name, "bcd_d", 8'(vif.dinheiro_inserido_d), 8'(e.d));
        chk(e.name, "bcd_u", 8'(vif.dinheiro_inserido_u), 8'(e.u));
        chk(e.name, "moedas_25", vif.moedas_carteira_25, e.m25);
        chk(e.name, "moedas_50", vif.moedas_carteira_50, e.m50);
        chk(e.name, "moedas_100", vif.moedas_carteira_100, e.m100);
      end
    end
  end

  task automatic expect_out(input int k, input string nm,
                            input logic [7:0] pv, input logic [7:0] cart, input logic [7:0] troco,
                            input logic [3:0] c, input logic [3:0] d, input logic [3:0] u,
                            input logic [7:0] m25, input logic [7:0] m50, input logic [7:0] m100);
    exp_t e;
    e.cyc = cyc + k; e.name = nm;
    e.pv = pv; e.cart = cart; e.troco = troco;
    e.c = c; e.d = d; e.u = u;
    e.m25 = m25; e.m50 = m50; e.m100 = m100;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    vif.escolher = 2'b00; vif.inserir_dinheiro = 2'b00; vif.dar_troco = 2'b00;
    vif.produto_escolhido = 8'd0; vif.dinheiro_inserido = 8'd0;
    vif.moedas_inseridas_25 = 8'd0; vif.moedas_inseridas_50 = 8'd0; vif.moedas_inseridas_100 = 8'd0;
  endtask

  // Apply one command for exactly one clock edge, then return inputs to idle
  task automatic cmd(input logic [1:0] esc, input logic [1:0] ins, input logic [1:0] dar,
                     input logic [7:0] prod, input logic [7:0] money,
                     input logic [7:0] n25, input logic [7:0] n50, input logic [7:0] n100);
    vif.escolher = esc; vif.inserir_dinheiro = ins; vif.dar_troco = dar;
    vif.produto_escolhido = prod; vif.dinheiro_inserido = money;
    vif.moedas_inseridas_25 = n25; vif.moedas_inseridas_50 = n50; vif.moedas_inseridas_100 = n100;
    tick();
    idle_inputs();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset_n = 1'b0;
    idle_inputs();
    #10 reset_n = 1'b1;
    tick();
    expect_out(0, "reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Invalid code and IDLE inserts/refunds are ignored
    cmd(2'b01, 2'b00, 2'b00, 8'd7, 8'd0, 0, 0, 0);
    cmd(2'b00, 2'b01, 2'b00, 8'd0, 8'd100, 0, 0, 1);
    cmd(2'b00, 2'b00, 2'b01, 8'd0, 8'd0, 0, 0, 0);
    expect_out(0, "bad_code", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Exact payment, code 2
    cmd(2'b01, 2'b00, 2'b00, 8'd2, 8'd0, 0, 0, 0);
    cmd(2'b00, 2'b01, 2'b00, 8'd0, 8'd100, 0, 0, 1);
    expect_out(0, "exact_credit", 0, 0, 0, 1, 0, 0, 0, 0, 0);
    expect_out(1, "exact_vender", 0, 0, 0, 1, 0, 0, 0, 0, 0);
    expect_out(2, "exact_sale", 2, 100, 0, 0, 0, 0, 0, 0, 1);
    repeat (2) tick();

    // Overpayment with change, code 1
    cmd(2'b01, 2'b00, 2'b00, 8'd1, 8'd0, 0, 0, 0);
    expect_out(0, "sel1_clear", 0, 100, 0, 0, 0, 0, 0, 0, 1);
    cmd(2'b00, 2'b01, 2'b00, 8'd0, 8'd50, 0, 1, 0);
    expect_out(0, "over_credit50", 0, 100, 0, 0, 5, 0, 0, 0, 1);
    cmd(2'b00, 2'b01, 2'b00, 8'd0, 8'd50, 0, 1, 0);
    expect_out(0, "over_credit100", 0, 100, 0, 1, 0, 0, 0, 0, 1);
    expect_out(2, "over_sale", 1, 175, 25, 0, 0, 0, 0, 2, 1);
    repeat (2) tick();

    // Refund with simultaneous insert, code 4
    cmd(2'b01, 2'b00, 2'b00, 8'd4, 8'd0, 0, 0, 0);
    cmd(2'b00, 2'b01, 2'b00, 8'd0, 8'd25, 1, 0, 0);
    expect_out(0, "refund_credit", 0, 175, 0, 0, 2, 5, 0, 2, 1);
    cmd(2'b00, 2'b01, 2'b01, 8'd0, 8'd50, 0, 1, 0);
    expect_out(0, "refund", 0, 175, 25, 0, 0, 0, 0, 2, 1);
    repeat (3) tick();
    expect_out(0, "refund_idle", 0, 175, 25, 0, 0, 0, 0, 2, 1);
    tick();

    // Saturation of credit and revenue; insert on the PAGAR->VENDER edge still counts
    cmd(2'b01, 2'b00, 2'b00, 8'd4, 8'd0, 0, 0, 0);
    cmd(2'b00, 2'b01, 2'b00, 8'd0, 8'd200, 0, 0, 2);
    expect_out(0, "sat_credit200", 0, 175, 0, 2, 0, 0, 0, 2, 1);
    cmd(2'b00, 2'b01, 2'b00, 8'd0, 8'd100, 0, 0, 1);
    expect_out(0, "sat_credit255", 0, 175, 0, 2, 5, 5, 0, 2, 1);
    expect_out(1, "sat_sale", 4, 255, 105, 0, 0, 0, 0, 2, 4);
    repeat (4) tick();
    expect_out(0, "sat_hold", 4, 255, 105, 0, 0, 0, 0, 2, 4);
    tick();
    cmd(2'b01, 2'b00, 2'b00, 8'd1, 8'd0, 0, 0, 0);
    cmd(2'b00, 2'b01, 2'b00, 8'd0, 8'd75, 3, 0, 0);
    expect_out(2, "cart_stuck255", 1, 255, 0, 0, 0, 0, 3, 2, 4);
    repeat (2) tick();

    // Asynchronous reset while in PAGAR with credit 75
    cmd(2'b01, 2'b00, 2'b00, 8'd4, 8'd0, 0, 0, 0);
    cmd(2'b00, 2'b01, 2'b00, 8'd0, 8'd75, 3, 0, 0);
    expect_out(0, "pre_reset", 0, 255, 0, 0, 7, 5, 3, 2, 4);
    tick();
    #1 reset_n = 1'b0;
    expect_out(0, "async_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #4 reset_n = 1'b1;
    tick();

    // Post-reset sale of code 3
    cmd(2'b01, 2'b00, 2'b00, 8'd3, 8'd0, 0, 0, 0);
    cmd(2'b00, 2'b01, 2'b00, 8'd0, 8'd125, 1, 0, 1);
    expect_out(2, "code3_sale", 3, 125, 0, 0, 0, 0, 1, 0, 1);
    repeat (2) tick();

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp = n_cmp + 1;
      n_bad = n_bad + 1;
      $display("FAIL %s: expectation never checked", e.name);
    end
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
